aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl: RTL and testbench

//  Downstream consumer of the debug-slave sysclk command strobes: executes JTAG on-chip-memory

---
 rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.sv | 27 ++
 rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv | 152 +++++++++++++++
 tb/tb_aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.sv
// rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.sv - command strobes and debug-RAM bus for the OCI memory controller
interface aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              debugack;
    logic [31:0]       ram_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, debugack, ram_rdata,
        output ram_addr, ram_wdata, ram_we, ram_re, MonDReg, monitor_ready, monitor_error
    );

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, debugack, ram_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_re, MonDReg, monitor_ready, monitor_error
    );
endinterface

// File: rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// rtl/aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv - executes JTAG set-address/read/write/clear commands on the CPU debug RAM
module aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 160,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset_n,
    aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR} state_e;

    localparam logic [1:0]        OP_SETA   = 2'b00;
    localparam logic [1:0]        OP_READ   = 2'b01;
    localparam logic [1:0]        OP_WRITE  = 2'b10;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        RD_DONE   = 3'(RD_LAT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       mon_q, mon_d;
    logic              ram_we_q, ram_we_d;
    logic              ram_re_q, ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [1:0]        op;
    logic              addr_ok;
    logic [ADDR_W-1:0] addr_inc;
    logic              unused_jdo;

    assign op         = bus.jdo[37:36];
    assign addr_ok    = 32'(addr_q) < DEPTH;
    assign addr_inc   = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    assign unused_jdo = ^bus.jdo[35:32];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mon_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ready_q     <= 1'b1;
            error_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mon_q       <= mon_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mon_d       = mon_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ready_d     = ready_q;
        error_d     = error_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.take_action_ocimem_a) begin
                    unique case (op)
                        OP_SETA: addr_d = bus.jdo[ADDR_W+1:2];
                        OP_READ: begin
                            if (!addr_ok) begin
                                error_d = 1'b1;
                            end else begin
                                ram_re_d   = 1'b1;
                                ram_addr_d = addr_q;
                                state_d    = S_RD_WAIT;
                                ready_d    = 1'b0;
                                cnt_d      = '0;
                            end
                        end
                        OP_WRITE: begin
                            if (!addr_ok || !bus.debugack) begin
                                error_d = 1'b1;
                            end else begin
                                ram_we_d    = 1'b1;
                                ram_addr_d  = addr_q;
                                ram_wdata_d = bus.jdo[31:0];
                                state_d     = S_WR;
                                ready_d     = 1'b0;
                                cnt_d       = '0;
                            end
                        end
                        default: error_d = 1'b0;
                    endcase
                end
            end
            S_RD_WAIT: begin
                // abort outranks the capture that would land on the same edge
                if (bus.take_action_ocimem_b) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == RD_DONE) begin
                    mon_d   = bus.ram_rdata;
                    addr_d  = addr_inc;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WR: begin
                // hold one cycle past the write pulse so ready means the word has landed
                if (cnt_q == 3'd1) begin
                    addr_d  = addr_inc;
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && bus.take_action_ocimem_a) begin
            error_d = 1'b1;
        end
    end

    assign bus.ram_addr      = ram_addr_q;
    assign bus.ram_wdata     = ram_wdata_q;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_re        = ram_re_q;
    assign bus.MonDReg       = mon_q;
    assign bus.monitor_ready = ready_q;
    assign bus.monitor_error = error_q;
endmodule

// File: tb/tb_aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv
// tb/tb_aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl.sv - scoreboard bench for the OCI memory controller
module tb_aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 160;
    localparam int RD_LAT = 2;

    localparam logic [1:0] OP_SETA  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_CLR   = 2'b11;

    localparam int EV_WE   = 0;
    localparam int EV_RE   = 1;
    localparam int EV_DONE = 2;

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    aes_enc_core_nios2_gen2_0_cpu_debug_ocimem_ctrl #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] seed_word(input int a);
        return (32'(a) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // environment RAM: words never written read back as seed_word(addr)
    logic [31:0]  ram [256];
    logic [255:0] ram_written = '0;
    logic [31:0]  pipe [RD_LAT];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[bus.ram_addr]         <= bus.ram_wdata;
            ram_written[bus.ram_addr] <= 1'b1;
        end
        if (bus.ram_re)
            pipe[0] <= ram_written[bus.ram_addr] ? ram[bus.ram_addr] : seed_word(int'(bus.ram_addr));
        else
            pipe[0] <= $urandom;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.ram_rdata = pipe[RD_LAT-1];

    // reference model
    logic [31:0] ref_mem [256];
    int          m_addr = 0;
    logic [31:0] m_mon = '0;
    logic        m_err = 1'b0;
    ev_t         exp_q[$];

    function automatic void push(input int kind, input int addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // monitor
    logic prev_ready = 1'b1;
    ev_t  got;
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.ram_we || bus.ram_re) begin
                check("we_re_exclusive", 64'(bus.ram_we & bus.ram_re), 64'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_access: we=%0b re=%0b addr=%0h, none expected",
                             bus.ram_we, bus.ram_re, bus.ram_addr);
                end else begin
                    got = exp_q.pop_front();
                    check("access_kind", 64'(bus.ram_we ? EV_WE : EV_RE), 64'(got.kind));
                    check("access_addr", 64'(bus.ram_addr), 64'(got.addr));
                    if (bus.ram_we) check("write_data", 64'(bus.ram_wdata), 64'(got.data));
                end
            end
            if (bus.monitor_ready === 1'b1 && prev_ready === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: ready rose with nothing expected");
                end else begin
                    got = exp_q.pop_front();
                    check("done_kind", 64'(EV_DONE), 64'(got.kind));
                    check("MonDReg", 64'(bus.MonDReg), 64'(got.data));
                end
            end
        end
        prev_ready = bus.monitor_ready;
    end

    task automatic strobe(input logic [1:0] op, input logic [31:0] data);
        bus.jdo = {op, 4'($urandom), data};
        bus.take_action_ocimem_a = 1'b1;
        @(negedge clk);
        bus.take_action_ocimem_a = 1'b0;
    endtask

    // abort_k / busy_k: extra cycles after the strobe at which b / a is raised (-1 = never)
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] data,
                          input int abort_k = -1, input int busy_k = -1);
        bit access = 0;
        int exp_lat = 0;
        int cnt;
        case (op)
            OP_SETA: m_addr = int'(data[ADDR_W+1:2]);
            OP_READ: begin
                if (m_addr >= DEPTH) m_err = 1'b1;
                else begin
                    access = 1;
                    push(EV_RE, m_addr, '0);
                    if (abort_k >= 0) begin
                        exp_lat = abort_k + 1;
                    end else begin
                        exp_lat = RD_LAT + 1;
                        m_mon = ref_mem[m_addr];
                        m_addr = (m_addr + 1) % DEPTH;
                    end
                    push(EV_DONE, 0, m_mon);
                end
            end
            OP_WRITE: begin
                if (m_addr >= DEPTH || !bus.debugack) m_err = 1'b1;
                else begin
                    access = 1;
                    exp_lat = 2;
                    push(EV_WE, m_addr, data);
                    ref_mem[m_addr] = data;
                    m_addr = (m_addr + 1) % DEPTH;
                    push(EV_DONE, 0, m_mon);
                end
            end
            default: m_err = 1'b0;
        endcase
        if (access && busy_k >= 0) m_err = 1'b1;

        strobe(op, data);
        if (access) begin
            cnt = 0;
            while (bus.monitor_ready !== 1'b1 && cnt < 20) begin
                if (cnt == abort_k) bus.take_action_ocimem_b = 1'b1;
                if (cnt == busy_k) begin
                    bus.jdo = {OP_READ, 4'd0, 32'($urandom)};
                    bus.take_action_ocimem_a = 1'b1;
                end
                @(negedge clk);
                bus.take_action_ocimem_b = 1'b0;
                bus.take_action_ocimem_a = 1'b0;
                cnt++;
            end
            check(op == OP_READ ? "read_latency" : "write_latency", 64'(cnt), 64'(exp_lat));
        end
        check("ready_after_cmd", 64'(bus.monitor_ready), 64'd1);
        check("error_after_cmd", 64'(bus.monitor_error), 64'(m_err));
    endtask

    task automatic seta(input int a);
        do_cmd(OP_SETA, (32'(a) << 2) | 32'($urandom_range(0, 3)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(bus.monitor_ready), 64'd1);
        check({tag, "_error"}, 64'(bus.monitor_error), 64'd0);
        check({tag, "_MonDReg"}, 64'(bus.MonDReg), 64'd0);
        check({tag, "_we"}, 64'(bus.ram_we), 64'd0);
        check({tag, "_re"}, 64'(bus.ram_re), 64'd0);
        check({tag, "_ram_addr"}, 64'(bus.ram_addr), 64'd0);
        check({tag, "_ram_wdata"}, 64'(bus.ram_wdata), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.debugack = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // set address then read proves addr=16
        seta(16);
        do_cmd(OP_READ, '0);

        // write / readback with latency
        seta(5);
        do_cmd(OP_WRITE, 32'hDEADBEEF);
        seta(5);
        do_cmd(OP_READ, '0);
        do_cmd(OP_READ, '0);

        // wrap at DEPTH-1, out-of-range read, clear
        seta(DEPTH - 1);
        do_cmd(OP_READ, '0);
        do_cmd(OP_READ, '0);
        seta(200);
        do_cmd(OP_READ, '0);
        do_cmd(OP_CLR, '0);

        // write without debugack, busy strobe during read
        seta(7);
        bus.debugack = 1'b0;
        do_cmd(OP_WRITE, 32'h12345678);
        bus.debugack = 1'b1;
        do_cmd(OP_CLR, '0);
        do_cmd(OP_READ, '0, -1, 1);
        do_cmd(OP_CLR, '0);

        // aborts: first wait cycle, on the capture edge, and together with strobe a
        seta(9);
        do_cmd(OP_WRITE, 32'hCAFEF00D);
        seta(9);
        do_cmd(OP_READ, '0, 0);
        do_cmd(OP_READ, '0, RD_LAT);
        do_cmd(OP_READ, '0, 0, 0);
        do_cmd(OP_CLR, '0);
        do_cmd(OP_READ, '0);

        // reset in the middle of a read
        seta(3);
        push(EV_RE, 3, '0);
        strobe(OP_READ, '0);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        m_addr = 0;
        m_mon = '0;
        m_err = 1'b0;
        @(negedge clk);
        check_reset_outputs("midread_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (RD_LAT + 2) @(negedge clk);
        check("late_rdata_ignored", 64'(bus.MonDReg), 64'd0);
        do_cmd(OP_READ, '0);

        // randomized mix
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            bus.debugack = ($urandom_range(0, 5) != 0);
            case (r)
                0, 1:    seta($urandom_range(0, 199));
                2, 3, 4: do_cmd(OP_READ, '0);
                5, 6, 7: do_cmd(OP_WRITE, 32'($urandom));
                8:       do_cmd(OP_CLR, '0);
                default: do_cmd(OP_READ, '0, $urandom_range(0, RD_LAT));
            endcase
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
